ac_exec_unit: RTL and testbench

//  Registered accumulator (AC) and carry/link flag (E) execution unit for the Mano-style CPU datapath.

---
 rtl/ac_exec_unit.sv | 132 +++++++++++++
 tb/tb_ac_exec_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ac_exec_unit.sv
// Accumulator (AC) and link flag (E) execution unit with a valid/ready op port.
// Every op except MUL completes at its accept edge; MUL is a WIDTH-cycle shift-add sequence.
module ac_exec_unit #(
  parameter int WIDTH  = 16,
  parameter int INPR_W = 8,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [WIDTH-1:0]  dr,
  input  logic [INPR_W-1:0] inpr,
  output logic [WIDTH-1:0]  ac,
  output logic              e,
  output logic              done,
  output logic              busy,
  output logic              ac_zero,
  output logic              ac_neg
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_AND = 4'd1,  OP_ADD = 4'd2,  OP_LDA = 4'd3;
  localparam logic [3:0] OP_INP = 4'd4,  OP_CMA = 4'd5,  OP_CIL = 4'd6,  OP_CIR = 4'd7;
  localparam logic [3:0] OP_CLA = 4'd8,  OP_CLE = 4'd9,  OP_CME = 4'd10, OP_INC = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_SUB = 4'd13;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     ac_q;
  logic                 e_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [WIDTH-1:0]     ac_d;
  logic                 e_d;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_sum;
  logic [2*WIDTH-1:0]   prod_d;
  logic                 accept;
  logic                 is_mul;

  assign busy     = (state_q == MUL);
  assign op_ready = ~busy;
  assign ac       = ac_q;
  assign e        = e_q;
  assign done     = done_q;
  assign ac_zero  = (ac_q == '0);
  assign ac_neg   = ac_q[WIDTH-1];

  assign accept = op_valid & op_ready;
  assign is_mul = (MUL_EN != 0) && (op_code == OP_MUL);

  // SUB is two's-complement addition, so the carry out reads as "no borrow".
  assign add_sum = {1'b0, ac_q} + {1'b0, dr};
  assign sub_sum = {1'b0, ac_q} + {1'b0, ~dr} + {{WIDTH{1'b0}}, 1'b1};

  // One shift-add step: multiplicand shifts left, multiplier bits consumed LSB first.
  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    ac_d = ac_q;
    e_d  = e_q;
    case (op_code)
      OP_AND: ac_d = ac_q & dr;
      OP_ADD: {e_d, ac_d} = add_sum;
      OP_LDA: ac_d = dr;
      OP_INP: ac_d = WIDTH'(inpr);
      OP_CMA: ac_d = ~ac_q;
      OP_CIL: {e_d, ac_d} = {ac_q, e_q};
      OP_CIR: {ac_d, e_d} = {e_q, ac_q};
      OP_CLA: ac_d = '0;
      OP_CLE: e_d = 1'b0;
      OP_CME: e_d = ~e_q;
      OP_INC: ac_d = ac_q + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_SUB: {e_d, ac_d} = sub_sum;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ac_q     <= '0;
      e_q      <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand_q  <= {{WIDTH{1'b0}}, ac_q};
              mplier_q <= dr;
              prod_q   <= '0;
              cnt_q    <= '0;
              state_q  <= MUL;
            end else begin
              ac_q   <= ac_d;
              e_q    <= e_d;
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            ac_q    <= prod_d[WIDTH-1:0];
            e_q     <= |prod_d[2*WIDTH-1:WIDTH];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_exec_unit.sv
// Directed plus random checks of ac_exec_unit against an arithmetic reference of AC/E.
module tb_ac_exec_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [3:0]    op_code = 4'd0;
  logic [W-1:0]  dr = '0;
  logic [7:0]    inpr = '0;
  logic [W-1:0]  ac;
  logic          e;
  logic          done;
  logic          busy;
  logic          ac_zero;
  logic          ac_neg;

  int checks = 0;
  int errors = 0;

  // Reference state
  int unsigned m_ac = 0;
  int unsigned m_e  = 0;

  ac_exec_unit #(.WIDTH(W), .INPR_W(8), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .dr(dr), .inpr(inpr), .ac(ac), .e(e),
    .done(done), .busy(busy), .ac_zero(ac_zero), .ac_neg(ac_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour computed with plain integer arithmetic
  task automatic model(input logic [3:0] op, input int unsigned d, input int unsigned in8);
    longint unsigned s;
    case (op)
      4'd1:  m_ac = m_ac & d;
      4'd2:  begin s = longint'(m_ac) + d; m_ac = int'(s % 65536); m_e = int'(s / 65536); end
      4'd3:  m_ac = d;
      4'd4:  m_ac = in8;
      4'd5:  m_ac = 65535 - m_ac;
      4'd6:  begin s = m_ac * 2 + m_e; m_e = int'(s / 65536); m_ac = int'(s % 65536); end
      4'd7:  begin s = m_e * 65536 + m_ac; m_e = int'(s % 2); m_ac = int'(s / 2); end
      4'd8:  m_ac = 0;
      4'd9:  m_e = 0;
      4'd10: m_e = 1 - m_e;
      4'd11: m_ac = (m_ac + 1) % 65536;
      4'd12: begin s = longint'(m_ac) * d; m_ac = int'(s % 65536); m_e = (s >= 65536) ? 1 : 0; end
      4'd13: begin s = longint'(m_ac) + (65535 - d) + 1; m_ac = int'(s % 65536); m_e = int'(s / 65536); end
      default: ;
    endcase
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".ac"}, 32'(ac), m_ac);
    chk({tag, ".e"}, 32'(e), m_e);
    chk({tag, ".zero"}, 32'(ac_zero), (m_ac == 0) ? 1 : 0);
    chk({tag, ".neg"}, 32'(ac_neg), (m_ac >= 32768) ? 1 : 0);
  endtask

  // Issue one op; MUL waits out the busy period while presenting junk ops that must be ignored.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] d, input logic [7:0] in8);
    int unsigned pre_ac;
    int unsigned pre_e;
    int          low;
    pre_ac = m_ac;
    pre_e  = m_e;
    op_valid = 1'b1; op_code = op; dr = d; inpr = in8;
    step();
    op_valid = 1'b0;
    model(op, d, in8);
    if (op == 4'd12) begin
      chk({tag, ".busy"}, 32'(busy), 1);
      low = 0;
      while (!op_ready && low < 64) begin
        low++;
        chk({tag, ".hold_ac"}, 32'(ac), pre_ac);
        chk({tag, ".hold_e"}, 32'(e), pre_e);
        chk({tag, ".nodone"}, 32'(done), 0);
        op_valid = 1'b1;
        op_code  = 4'($urandom_range(0, 15));
        dr       = W'($urandom);
        inpr     = 8'($urandom);
        step();
      end
      op_valid = 1'b0;
      chk({tag, ".ready_low_cycles"}, 32'(low), W);
      chk({tag, ".done"}, 32'(done), 1);
      chk_state(tag);
      step();
      chk({tag, ".done_once"}, 32'(done), 0);
    end else begin
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".ready"}, 32'(op_ready), 1);
      chk_state(tag);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.ac", 32'(ac), 0);
    chk("rst.e", 32'(e), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ready", 32'(op_ready), 1);
    step();
    rst = 1'b0;
    step();

    // ADD with carry out
    issue("lda_ffff", 4'd3, 16'hFFFF, 8'h00);
    issue("add_wrap", 4'd2, 16'h0001, 8'h00);
    chk("add_wrap.ac_exact", 32'(ac), 32'h0000);
    chk("add_wrap.e_exact", 32'(e), 1);
    step();
    chk("add_wrap.done_once", 32'(done), 0);

    // Rotates through E
    issue("lda_8001", 4'd3, 16'h8001, 8'h00);
    issue("cle", 4'd9, 16'h0000, 8'h00);
    issue("cil", 4'd6, 16'h1234, 8'h00);
    chk("cil.ac_exact", 32'(ac), 32'h0002);
    issue("cir", 4'd7, 16'h1234, 8'h00);
    chk("cir.ac_exact", 32'(ac), 32'h8001);

    // INP zero-extends; SUB with borrow
    issue("inp", 4'd4, 16'hFFFF, 8'hA5);
    chk("inp.ac_exact", 32'(ac), 32'h00A5);
    issue("lda_5", 4'd3, 16'd5, 8'h00);
    issue("sub", 4'd13, 16'd7, 8'h00);
    chk("sub.ac_exact", 32'(ac), 32'hFFFE);
    chk("sub.e_exact", 32'(e), 0);

    // MUL cases
    issue("lda_0123", 4'd3, 16'h0123, 8'h00);
    issue("mul_a", 4'd12, 16'h0010, 8'h00);
    chk("mul_a.ac_exact", 32'(ac), 32'h1230);
    issue("lda_0100", 4'd3, 16'h0100, 8'h00);
    issue("mul_ovf", 4'd12, 16'h0100, 8'h00);
    chk("mul_ovf.e_exact", 32'(e), 1);

    // Back-to-back single-cycle ops
    issue("b2b_lda", 4'd3, 16'd3, 8'h00);
    issue("b2b_inc", 4'd11, 16'h5555, 8'h00);
    issue("b2b_cma", 4'd5, 16'h5555, 8'h00);
    chk("b2b.ac_exact", 32'(ac), 32'hFFFB);

    // Random ops against the reference
    for (int i = 0; i < 60; i++) begin
      issue($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), W'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("rnd_idle.done", 32'(done), 0);
        chk_state("rnd_idle");
      end
    end

    // Asynchronous reset in the middle of a MUL
    issue("lda_rst", 4'd3, 16'h0F0F, 8'h00);
    op_valid = 1'b1; op_code = 4'd12; dr = 16'h0303;
    step();
    op_valid = 1'b0;
    chk("rstmul.busy", 32'(busy), 1);
    repeat (7) step();
    #2;
    rst = 1'b1;
    #1;
    m_ac = 0;
    m_e  = 0;
    chk("rstmul.busy_now", 32'(busy), 0);
    chk("rstmul.ready_now", 32'(op_ready), 1);
    chk_state("rstmul");
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rstmul.no_done", 32'(done), 0);
      chk("rstmul.ac_held", 32'(ac), 0);
    end
    issue("post_rst_lda", 4'd3, 16'h1234, 8'h00);
    issue("post_rst_mul", 4'd12, 16'h0003, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
